// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the
// enable/flush bundle driven into the pipeline registers, and helpers.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hazard_state_t;

    localparam logic [2:0] REG_ZERO   = 3'd0;
    localparam int         WAIT_CNT_W = 8;

    typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

    typedef struct packed {
        logic pc_enable;
        logic if_id_enable;
        logic if_id_flush;
        logic id_ex_enable;
        logic id_ex_flush;
        logic ex_mem_enable;
        logic mem_wb_enable;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FREEZE = '0;

    // Normal flow: every stage advances, nothing is squashed.
    function automatic pipe_ctrl_t ctrl_run();
        pipe_ctrl_t c;
        c               = '0;
        c.pc_enable     = 1'b1;
        c.if_id_enable  = 1'b1;
        c.id_ex_enable  = 1'b1;
        c.ex_mem_enable = 1'b1;
        c.mem_wb_enable = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: pipeline status in, stage enables/flushes out.
// Stall_Count exists only when HAZARD_STALL_CNT_EN is defined.
interface pipeline_hazard_controller_if
`ifdef HAZARD_STALL_CNT_EN
    #(parameter int STALL_CNT_W = 16)
`endif
    ;

    logic [2:0] ID_Rs;
    logic [2:0] ID_Rt;
    logic       ID_Uses_Rt;
    logic       ID_Jump;
    logic       EX_Mem_Read;
    logic       EX_Reg_Write;
    logic [2:0] EX_Write_Reg;
    logic       EX_Branch_Taken;
    logic       Mem_Req;
    logic       Mem_Ready;

    logic       PC_Enable;
    logic       IF_ID_Enable;
    logic       IF_ID_Flush;
    logic       ID_EX_Enable;
    logic       ID_EX_Flush;
    logic       EX_MEM_Enable;
    logic       MEM_WB_Enable;
    logic       Mem_Timeout;
`ifdef HAZARD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] Stall_Count;
`endif

    // Master is the pipeline datapath, slave is the hazard controller.
    modport master (
`ifdef HAZARD_STALL_CNT_EN
        input  Stall_Count,
`endif
        output ID_Rs, ID_Rt, ID_Uses_Rt, ID_Jump,
        output EX_Mem_Read, EX_Reg_Write, EX_Write_Reg, EX_Branch_Taken,
        output Mem_Req, Mem_Ready,
        input  PC_Enable, IF_ID_Enable, IF_ID_Flush, ID_EX_Enable,
        input  ID_EX_Flush, EX_MEM_Enable, MEM_WB_Enable, Mem_Timeout
    );

    modport slave (
`ifdef HAZARD_STALL_CNT_EN
        output Stall_Count,
`endif
        input  ID_Rs, ID_Rt, ID_Uses_Rt, ID_Jump,
        input  EX_Mem_Read, EX_Reg_Write, EX_Write_Reg, EX_Branch_Taken,
        input  Mem_Req, Mem_Ready,
        output PC_Enable, IF_ID_Enable, IF_ID_Flush, ID_EX_Enable,
        output ID_EX_Flush, EX_MEM_Enable, MEM_WB_Enable, Mem_Timeout
    );

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Combinational load-use comparator: a LW in EX writing a register that the
// ID instruction reads. Kept standalone so the forwarding unit can reuse it.
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [2:0] ex_write_reg,
    input  logic [2:0] id_rs,
    input  logic [2:0] id_rt,
    input  logic       id_uses_rt,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (id_rs == ex_write_reg);
    assign rt_match = id_uses_rt && (id_rt == ex_write_reg);

    // r0 is hardwired to zero, so a load into it never creates a dependency.
    assign hazard = ex_mem_read && ex_reg_write &&
                    (ex_write_reg != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline, with a memory
// wait-state watchdog. Optional stall counter: define HAZARD_STALL_CNT_EN.
module pipeline_hazard_controller
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
`ifdef HAZARD_STALL_CNT_EN
    ,
    parameter int STALL_CNT_W  = 16
`endif
)
(
    input logic                         clk,
    input logic                         Rst_N,
    pipeline_hazard_controller_if.slave bus
);

    hazard_state_t state;
    hazard_state_t next_state;
    wait_cnt_t     wait_cnt;
    wait_cnt_t     next_wait_cnt;
    logic          timeout_q;
    logic          next_timeout;
    logic          load_use;
    pipe_ctrl_t    ctrl;

    load_use_detect u_load_use_detect (
        .ex_mem_read  (bus.EX_Mem_Read),
        .ex_reg_write (bus.EX_Reg_Write),
        .ex_write_reg (bus.EX_Write_Reg),
        .id_rs        (bus.ID_Rs),
        .id_rt        (bus.ID_Rt),
        .id_uses_rt   (bus.ID_Uses_Rt),
        .hazard       (load_use)
    );

    always_ff @(posedge clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= next_state;
            wait_cnt  <= next_wait_cnt;
            timeout_q <= next_timeout;
        end
    end

    // In RUN a stalled memory access outranks everything, since nothing may
    // move while MEM is blocked; a taken branch then squashes ID, which makes
    // any load-use or jump decode in ID irrelevant.
    always_comb begin
        next_state    = state;
        next_wait_cnt = wait_cnt;
        next_timeout  = timeout_q;
        ctrl          = CTRL_FREEZE;

        unique case (state)
            RUN: begin
                if (bus.Mem_Req && !bus.Mem_Ready) begin
                    next_state    = MEM_WAIT;
                    next_wait_cnt = wait_cnt_t'(1);
                end else if (bus.EX_Branch_Taken) begin
                    ctrl             = ctrl_run();
                    ctrl.if_id_flush = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                end else if (load_use) begin
                    ctrl              = ctrl_run();
                    ctrl.pc_enable    = 1'b0;
                    ctrl.if_id_enable = 1'b0;
                    ctrl.id_ex_flush  = 1'b1;
                end else if (bus.ID_Jump) begin
                    ctrl             = ctrl_run();
                    ctrl.if_id_flush = 1'b1;
                end else begin
                    ctrl = ctrl_run();
                end
            end

            // Hazards seen while frozen stay in their registers and are
            // decoded again on the first RUN cycle after release.
            MEM_WAIT: begin
                if (bus.Mem_Ready) begin
                    ctrl          = ctrl_run();
                    next_state    = RUN;
                    next_wait_cnt = '0;
                end else if (wait_cnt == wait_cnt_t'(MEM_WAIT_MAX)) begin
                    next_state   = FAULT;
                    next_timeout = 1'b1;
                end else if (wait_cnt != '1) begin
                    next_wait_cnt = wait_cnt + wait_cnt_t'(1);
                end
            end

            FAULT: begin
                next_timeout = 1'b1;
            end

            default: begin
                next_state    = RUN;
                next_wait_cnt = '0;
            end
        endcase

        if (!Rst_N) begin
            ctrl = CTRL_FREEZE;
        end
    end

    assign bus.PC_Enable     = ctrl.pc_enable;
    assign bus.IF_ID_Enable  = ctrl.if_id_enable;
    assign bus.IF_ID_Flush   = ctrl.if_id_flush;
    assign bus.ID_EX_Enable  = ctrl.id_ex_enable;
    assign bus.ID_EX_Flush   = ctrl.id_ex_flush;
    assign bus.EX_MEM_Enable = ctrl.ex_mem_enable;
    assign bus.MEM_WB_Enable = ctrl.mem_wb_enable;
    assign bus.Mem_Timeout   = timeout_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Cycles lost to a held PC, excluding time parked in FAULT.
    always_ff @(posedge clk or negedge Rst_N) begin
        if (!Rst_N) begin
            stall_cnt <= '0;
        end else if (!ctrl.pc_enable && (state != FAULT) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.Stall_Count = stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios then
// random traffic, all compared against a rule-level reference model.
module tb_pipeline_hazard_controller;

    localparam int WAIT_MAX = 4;

    logic clk   = 1'b0;
    logic Rst_N = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_controller_if bus ();

    pipeline_hazard_controller #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .Rst_N (Rst_N),
        .bus   (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: memory access outcome tracked as plain flags/counts.
    bit m_fault;
    bit m_waiting;
    int m_wait_len;
    int m_stalls;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Outputs ordered {PC, IF_ID_En, IF_ID_Fl, ID_EX_En, ID_EX_Fl, EX_MEM_En, MEM_WB_En}.
    task automatic applyStimulus(input bit rst_n, input bit [2:0] rs, input bit [2:0] rt,
                                 input bit uses_rt, input bit jump, input bit mem_read,
                                 input bit reg_write, input bit [2:0] wr, input bit br,
                                 input bit req, input bit rdy);
        bit [6:0] exp_ctrl;
        bit       hazard;
        bit       exp_timeout;
        @(negedge clk);
        bus.ID_Rs           = rs;
        bus.ID_Rt           = rt;
        bus.ID_Uses_Rt      = uses_rt;
        bus.ID_Jump         = jump;
        bus.EX_Mem_Read     = mem_read;
        bus.EX_Reg_Write    = reg_write;
        bus.EX_Write_Reg    = wr;
        bus.EX_Branch_Taken = br;
        bus.Mem_Req         = req;
        bus.Mem_Ready       = rdy;
        Rst_N               = rst_n;
        #1;
        if (!rst_n) begin
            m_fault    = 0;
            m_waiting  = 0;
            m_wait_len = 0;
            m_stalls   = 0;
        end
        hazard = mem_read && reg_write && (wr != 0) &&
                 ((rs == wr) || (uses_rt && (rt == wr)));
        exp_timeout = m_fault;
        exp_ctrl    = 7'b0000000;

        if (!rst_n || m_fault) begin
            exp_ctrl = 7'b0000000;
        end else if (m_waiting) begin
            if (rdy) exp_ctrl = 7'b1101011;
        end else if (req && !rdy) begin
            exp_ctrl = 7'b0000000;
        end else if (br) begin
            exp_ctrl = 7'b1111111;
        end else if (hazard) begin
            exp_ctrl = 7'b0001111;
        end else if (jump) begin
            exp_ctrl = 7'b1111011;
        end else begin
            exp_ctrl = 7'b1101011;
        end

        checkOutput($sformatf("ctrl@%0d", vectors),
                    {24'd0, bus.PC_Enable, bus.IF_ID_Enable, bus.IF_ID_Flush,
                     bus.ID_EX_Enable, bus.ID_EX_Flush, bus.EX_MEM_Enable,
                     bus.MEM_WB_Enable, bus.Mem_Timeout},
                    {24'd0, exp_ctrl, exp_timeout});
`ifdef HAZARD_STALL_CNT_EN
        checkOutput($sformatf("stall_count@%0d", vectors),
                    {16'd0, bus.Stall_Count}, m_stalls);
`endif

        // Advance the model to the state after the coming rising edge.
        if (rst_n) begin
            if (!exp_ctrl[6] && !m_fault && m_stalls < 65535) m_stalls++;
            if (m_fault) begin
                m_fault = 1;
            end else if (m_waiting) begin
                if (rdy) begin
                    m_waiting  = 0;
                    m_wait_len = 0;
                end else if (m_wait_len == WAIT_MAX) begin
                    m_waiting = 0;
                    m_fault   = 1;
                end else begin
                    m_wait_len++;
                end
            end else if (req && !rdy) begin
                m_waiting  = 1;
                m_wait_len = 1;
            end
        end
    endtask

    initial begin
        bit rn, uses, jmp, mrd, rw, brt, rq, rd;
        bit [2:0] ra, rb, rwd;

        $display("[TB] start, MEM_WAIT_MAX=%0d", WAIT_MAX);
        m_fault = 0; m_waiting = 0; m_wait_len = 0; m_stalls = 0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 3'd2, 3'd2, 1, 1, 1, 1, 3'd2, 1, 1, 0);

        // LW r2 in EX with ID reading r2: one bubble, then free flow.
        applyStimulus(1, 3'd2, 3'd5, 0, 0, 1, 1, 3'd2, 0, 0, 0);
        applyStimulus(1, 3'd2, 3'd5, 0, 0, 0, 0, 3'd0, 0, 0, 0);
        // Loads to r0, and Rt match without ID_Uses_Rt, never stall.
        applyStimulus(1, 3'd0, 3'd1, 1, 0, 1, 1, 3'd0, 0, 0, 0);
        applyStimulus(1, 3'd1, 3'd3, 0, 0, 1, 1, 3'd3, 0, 0, 0);
        applyStimulus(1, 3'd1, 3'd3, 1, 0, 1, 1, 3'd3, 0, 0, 0);
        // Memory holds three cycles, then completes.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        // Request and ready together: no wait, branch rules apply.
        applyStimulus(1, 3'd4, 0, 0, 1, 1, 1, 3'd4, 1, 1, 1);
        applyStimulus(1, 3'd4, 0, 0, 1, 0, 0, 3'd0, 0, 0, 0);
        // Unanswered request runs into the watchdog, then stays trapped.
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset pulse in the middle of a wait abandons the request.
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 3'd3, 0, 0, 0, 1, 1, 3'd3, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            rn   = ($urandom_range(0, 63) != 0);
            ra   = 3'($urandom_range(0, 3));
            rb   = 3'($urandom_range(0, 3));
            rwd  = 3'($urandom_range(0, 3));
            uses = 1'($urandom);
            jmp  = ($urandom_range(0, 5) == 0);
            mrd  = 1'($urandom);
            rw   = ($urandom_range(0, 3) != 0);
            brt  = ($urandom_range(0, 5) == 0);
            rq   = ($urandom_range(0, 3) == 0);
            rd   = 1'($urandom);
            applyStimulus(rn, ra, rb, uses, jmp, mrd, rw, rwd, brt, rq, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
